// File: rtl/i2c_pkg.sv
// Shared types and constants for the single-byte I2C master.
// The state encoding is common to the FSM and any bus monitors.
package i2c_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    ADDR,
    ACK_A,
    DATA,
    ACK_D,
    STOP
  } i2c_state_t;

  localparam logic I2C_WRITE = 1'b0;
  localparam logic I2C_READ  = 1'b1;
  localparam logic I2C_ACK   = 1'b0;
  localparam logic I2C_NACK  = 1'b1;

endpackage

// File: rtl/i2c_shift8.sv
// 8-bit shift register: parallel load, shift left with serial input.
// Serves both as the transmit serializer and the receive deserializer.
module i2c_shift8 (
  input  logic       clk_in,
  input  logic       resetN,
  input  logic       load,
  input  logic [7:0] load_val,
  input  logic       shift,
  input  logic       din,
  output logic [7:0] q,
  output logic       msb
);

  always_ff @(posedge clk_in or negedge resetN) begin
    if (!resetN) begin
      q <= '0;
    end else if (load) begin
      q <= load_val;
    end else if (shift) begin
      q <= {q[6:0], din};
    end
  end

  assign msb = q[7];

endmodule

// File: rtl/i2c_master_fsm.sv
// Single-byte I2C master: START, address+R/W, ACK, one data byte, STOP.
// Paced by the one-cycle SCL rise/fall strobes from gen_clk.
module i2c_master_fsm
  import i2c_pkg::*;
#(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 8
) (
  input  logic              clk_in,
  input  logic              resetN,
  input  logic              scl_posedge,
  input  logic              scl_negedge,
  input  logic              start,
  input  logic              rw,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              sda_i,
  output logic              scl_o,
  output logic              sda_o,
  output logic              busy,
  output logic              done,
  output logic              ack_err,
  output logic [DATA_W-1:0] rdata
);

  i2c_state_t        state;
  logic [2:0]        bitcnt;
  logic              rw_q;
  logic [DATA_W-1:0] wdata_q;
  logic              samp;
  logic              pos;
  logic              neg;

  logic              sr_load;
  logic [7:0]        sr_val;
  logic              sr_shift;
  logic [7:0]        sr_q;
  logic              sr_msb;

  // posedge wins when both strobes fire together
  assign pos = scl_posedge;
  assign neg = scl_negedge & ~scl_posedge;

  always_comb begin
    sr_load  = 1'b0;
    sr_val   = {addr, rw};
    sr_shift = 1'b0;
    if (state == IDLE && start && !busy) begin
      sr_load = 1'b1;
    end else if (state == ACK_A && neg && samp == I2C_ACK) begin
      sr_load = 1'b1;
      sr_val  = wdata_q;
    end else if (state == ADDR && neg && bitcnt != 3'd0) begin
      sr_shift = 1'b1;
    end else if (state == DATA && rw_q != I2C_READ
                 && neg && bitcnt != 3'd0) begin
      sr_shift = 1'b1;
    end else if (state == DATA && rw_q == I2C_READ && pos) begin
      sr_shift = 1'b1;
    end
  end

  i2c_shift8 u_sr (
    .clk_in   (clk_in),
    .resetN   (resetN),
    .load     (sr_load),
    .load_val (sr_val),
    .shift    (sr_shift),
    .din      (sda_i),
    .q        (sr_q),
    .msb      (sr_msb)
  );

  always_ff @(posedge clk_in or negedge resetN) begin
    if (!resetN) begin
      state   <= IDLE;
      scl_o   <= 1'b1;
      sda_o   <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
      ack_err <= 1'b0;
      rdata   <= '0;
      bitcnt  <= '0;
      rw_q    <= 1'b0;
      wdata_q <= '0;
      samp    <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          scl_o <= 1'b1;
          sda_o <= 1'b1;
          if (start && !busy) begin
            rw_q    <= rw;
            wdata_q <= wdata;
            ack_err <= 1'b0;
            busy    <= 1'b1;
            state   <= START;
          end
        end
        // a fall seen before the START rise is ignored via sda_o
        START: begin
          if (pos) begin
            sda_o <= 1'b0;
          end else if (neg && !sda_o) begin
            scl_o  <= 1'b0;
            sda_o  <= sr_msb;
            bitcnt <= 3'd7;
            state  <= ADDR;
          end
        end
        ADDR, DATA: begin
          if (pos) begin
            scl_o <= 1'b1;
            samp  <= sda_i;
          end else if (neg) begin
            scl_o <= 1'b0;
            if (bitcnt == 3'd0) begin
              sda_o <= 1'b1;
              state <= (state == ADDR) ? ACK_A : ACK_D;
            end else begin
              bitcnt <= bitcnt - 3'd1;
              sda_o  <= (state == DATA && rw_q == I2C_READ)
                        ? 1'b1 : sr_q[6];
            end
          end
        end
        ACK_A: begin
          if (pos) begin
            scl_o <= 1'b1;
            samp  <= sda_i;
          end else if (neg) begin
            scl_o <= 1'b0;
            if (samp == I2C_NACK) begin
              ack_err <= 1'b1;
              sda_o   <= 1'b0;
              state   <= STOP;
            end else begin
              bitcnt <= 3'd7;
              sda_o  <= (rw_q == I2C_READ) ? 1'b1 : wdata_q[DATA_W-1];
              state  <= DATA;
            end
          end
        end
        ACK_D: begin
          if (pos) begin
            scl_o <= 1'b1;
            if (rw_q == I2C_WRITE && sda_i == I2C_NACK) ack_err <= 1'b1;
          end else if (neg) begin
            scl_o <= 1'b0;
            sda_o <= 1'b0;
            state <= STOP;
          end
        end
        STOP: begin
          if (pos) begin
            scl_o <= 1'b1;
          end else if (neg && scl_o) begin
            sda_o <= 1'b1;
            done  <= 1'b1;
            busy  <= 1'b0;
            if (rw_q == I2C_READ) rdata <= sr_q;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_master_fsm.sv
// Directed bench for i2c_master_fsm with a gen_clk strobe model
// (divide_by=4) and a simple open-drain slave on SDA.
module tb_i2c_master_fsm;

  logic       clk_in = 1'b0;
  logic       resetN = 1'b0;
  logic       start  = 1'b0;
  logic       rw     = 1'b0;
  logic [6:0] addr   = '0;
  logic [7:0] wdata  = '0;
  logic       sda_i;
  logic       scl_posedge;
  logic       scl_negedge;
  logic       scl_o;
  logic       sda_o;
  logic       busy;
  logic       done;
  logic       ack_err;
  logic [7:0] rdata;

  int n_chk  = 0;
  int n_fail = 0;

  logic [1:0] div_cnt;
  logic       slave_sda = 1'b1;
  logic       s_read    = 1'b0;
  logic       s_nack_a  = 1'b0;
  logic [7:0] s_byte    = '0;

  int          rises = 0;
  int          falls = 0;
  int          stops = 0;
  int          dones = 0;
  logic [31:0] rvec  = '0;
  logic        p_scl  = 1'b1;
  logic        p_line = 1'b1;

  always #5 clk_in = ~clk_in;

  always @(posedge clk_in or negedge resetN) begin
    if (!resetN) div_cnt <= '0;
    else         div_cnt <= div_cnt + 2'd1;
  end

  assign scl_posedge = resetN && (div_cnt == 2'd0);
  assign scl_negedge = resetN && (div_cnt == 2'd2);
  assign sda_i       = sda_o & slave_sda;

  i2c_master_fsm dut (
    .clk_in      (clk_in),
    .resetN      (resetN),
    .scl_posedge (scl_posedge),
    .scl_negedge (scl_negedge),
    .start       (start),
    .rw          (rw),
    .addr        (addr),
    .wdata       (wdata),
    .sda_i       (sda_i),
    .scl_o       (scl_o),
    .sda_o       (sda_o),
    .busy        (busy),
    .done        (done),
    .ack_err     (ack_err),
    .rdata       (rdata)
  );

  // slot 0..7 addr/rw, 8 addr ack, 9..16 data, 17 data ack
  function automatic logic sbit(input int s);
    if (s == 8) return s_nack_a;
    if (!s_read && !s_nack_a && s == 17) return 1'b0;
    if (s_read && s >= 9 && s <= 16) return s_byte[16 - s];
    return 1'b1;
  endfunction

  always @(posedge clk_in) begin
    logic line;
    #1;
    line = sda_o & slave_sda;
    if (p_scl && scl_o && p_line && !line) begin
      rises = 0;
      falls = 0;
      stops = 0;
      rvec  = '0;
    end else if (p_scl && scl_o && !p_line && line) begin
      stops++;
    end
    if (p_scl && !scl_o) begin
      falls++;
      slave_sda = sbit(falls - 1);
    end
    if (!p_scl && scl_o) begin
      rises++;
      rvec = {rvec[30:0], line};
    end
    if (done) dones++;
    p_scl  = scl_o;
    p_line = sda_o & slave_sda;
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic run_tx(input logic r, input logic [6:0] a,
                        input logic [7:0] d, input logic nack,
                        input logic [7:0] sb, input bit mid,
                        input bit chk_acc, input int d0);
    int n;
    s_read   = r;
    s_nack_a = nack;
    s_byte   = sb;
    @(negedge clk_in);
    rw    = r;
    addr  = a;
    wdata = d;
    start = 1'b1;
    @(negedge clk_in);
    start = 1'b0;
    if (chk_acc) begin
      check("busy_acc", 32'(busy), 32'd1);
      check("ackerr_clr", 32'(ack_err), 32'd0);
    end
    n = 0;
    while (dones == d0 && n < 400) begin
      @(negedge clk_in);
      n++;
      if (mid && n == 40) begin
        start = 1'b1;
        addr  = 7'h7F;
        rw    = ~r;
      end else if (mid && n == 41) begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    repeat (4) @(negedge clk_in);
    check("done_once", 32'(dones - d0), 32'd1);
    check("busy_end", 32'(busy), 32'd0);
  endtask

  initial begin
    int viol;
    int n;
    int d0;

    repeat (3) @(negedge clk_in);
    check("rst_scl", 32'(scl_o), 32'd1);
    check("rst_sda", 32'(sda_o), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_ackerr", 32'(ack_err), 32'd0);
    check("rst_rdata", 32'(rdata), 32'd0);
    resetN = 1'b1;

    viol = 0;
    repeat (100) begin
      @(negedge clk_in);
      if (scl_o !== 1'b1 || sda_o !== 1'b1 || busy !== 1'b0) viol++;
    end
    check("idle_quiet", 32'(viol), 32'd0);

    run_tx(1'b0, 7'h50, 8'hA5, 1'b0, 8'h00, 1'b0, 1'b0, dones);
    check("wr_ackerr", 32'(ack_err), 32'd0);
    check("wr_rises", 32'(rises), 32'd19);
    check("wr_bits", rvec,
          32'({7'h50, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b0}));
    check("wr_stop", 32'(stops), 32'd1);

    run_tx(1'b1, 7'h28, 8'h00, 1'b0, 8'h3C, 1'b0, 1'b0, dones);
    check("rd_rdata", 32'(rdata), 32'h3C);
    check("rd_ackerr", 32'(ack_err), 32'd0);
    check("rd_bits", rvec,
          32'({7'h28, 1'b1, 1'b0, 8'h3C, 1'b1, 1'b0}));

    run_tx(1'b0, 7'h12, 8'hFF, 1'b1, 8'h00, 1'b0, 1'b0, dones);
    check("nack_ackerr", 32'(ack_err), 32'd1);
    check("nack_rises", 32'(rises), 32'd10);
    check("nack_bits", rvec, 32'({7'h12, 1'b0, 1'b1, 1'b0}));
    check("nack_stop", 32'(stops), 32'd1);
    check("nack_rdata", 32'(rdata), 32'h3C);

    run_tx(1'b0, 7'h50, 8'hA5, 1'b0, 8'h00, 1'b1, 1'b1, dones);
    check("mid_ackerr", 32'(ack_err), 32'd0);
    check("mid_bits", rvec,
          32'({7'h50, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b0}));

    s_read   = 1'b0;
    s_nack_a = 1'b0;
    @(negedge clk_in);
    rw    = 1'b0;
    addr  = 7'h3A;
    wdata = 8'hFF;
    start = 1'b1;
    @(negedge clk_in);
    start = 1'b0;
    n = 0;
    while (rises < 12 && n < 400) begin
      @(negedge clk_in);
      n++;
    end
    check("rst_reach_data", 32'(rises >= 12), 32'd1);
    d0 = dones;
    resetN = 1'b0;
    #1;
    check("arst_scl", 32'(scl_o), 32'd1);
    check("arst_sda", 32'(sda_o), 32'd1);
    check("arst_busy", 32'(busy), 32'd0);
    repeat (5) @(negedge clk_in);
    resetN = 1'b1;
    repeat (5) @(negedge clk_in);
    check("arst_nodone", 32'(dones - d0), 32'd0);

    run_tx(1'b0, 7'h3A, 8'h5C, 1'b0, 8'h00, 1'b0, 1'b0, dones);
    check("re_ackerr", 32'(ack_err), 32'd0);
    check("re_bits", rvec,
          32'({7'h3A, 1'b0, 1'b0, 8'h5C, 1'b0, 1'b0}));

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
